// File: rtl/irr_pkg.sv
// irr_pkg: shared constants and channel mode type for the interrupt request register.
package irr_pkg;
    localparam int IRR_N_DEFAULT    = 8;
    localparam int IRR_SYNC_DEFAULT = 2;
    typedef enum logic {IRR_EDGE = 1'b0, IRR_LEVEL = 1'b1} irr_mode_t;
endpackage

// File: rtl/irr_sync.sv
// irr_sync: N-bit, STAGES-deep flop synchronizer with synchronous reset to 0.
module irr_sync #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] stg_q [STAGES];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
        end else begin
            stg_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) stg_q[s] <= stg_q[s-1];
        end
    end
    assign q_o = stg_q[STAGES-1];
endmodule

// File: rtl/irr_bank.sv
// irr_bank: PIC interrupt request register with per-channel edge/level capture, INTA freeze and ack-clear.
// Define IRR_SYNC_EN to pass IRR through an irr_sync synchronizer before edge/level detection.
module irr_bank
    import irr_pkg::*;
#(
    parameter int N_IRQ       = IRR_N_DEFAULT,
    parameter int SYNC_STAGES = IRR_SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             IRR_reset,
    input  logic [N_IRQ-1:0] IRR,
    input  logic [N_IRQ-1:0] LTIM,
    input  logic             INTA_FREEZE,
    input  logic [N_IRQ-1:0] INTA_1,
    output logic [N_IRQ-1:0] IRR_priority,
    output logic [N_IRQ-1:0] IRR_control,
    output logic             irr_any
);
    logic [N_IRQ-1:0] ir, rise, set;
    logic [N_IRQ-1:0] pend_q, pend_d, prev_q, hold_q, hold_d, blk_q, blk_d;

    if (N_IRQ < 1 || N_IRQ > 32 || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("irr_bank: N_IRQ must be 1..32 and SYNC_STAGES >= 2");
    end

`ifdef IRR_SYNC_EN
    irr_sync #(.N(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (IRR_reset),
        .d_i (IRR),
        .q_o (ir)
    );
`else
    assign ir = IRR;
`endif

    assign rise = ir & ~prev_q;

    for (genvar c = 0; c < N_IRQ; c++) begin : g_ch
        logic lvl;
        assign lvl = irr_mode_t'(LTIM[c]) == IRR_LEVEL;
        // an ack in the same cycle already masks the level term, so the held request drops at once
        assign set[c]    = lvl ? ir[c] & ~(blk_q[c] | INTA_1[c]) : rise[c];
        assign pend_d[c] = INTA_FREEZE ? pend_q[c] & ~INTA_1[c]
                         : ((~lvl & pend_q[c] & ~INTA_1[c]) | set[c] | hold_q[c]);
        assign hold_d[c] = INTA_FREEZE & (hold_q[c] | (~lvl & rise[c]));
        assign blk_d[c]  = lvl & (INTA_1[c] | (blk_q[c] & ir[c]));
    end

    always_ff @(posedge clk) begin
        if (IRR_reset) begin
            pend_q <= '0;
            prev_q <= '0;
            hold_q <= '0;
            blk_q  <= '0;
        end else begin
            pend_q <= pend_d;
            prev_q <= ir;
            hold_q <= hold_d;
            blk_q  <= blk_d;
        end
    end

    assign IRR_priority = pend_q;
    assign IRR_control  = pend_q;
    assign irr_any      = |pend_q;
endmodule

// File: tb/tb_irr_bank.sv
// tb_irr_bank: scoreboard bench for irr_bank; directed cases plus a modelled random run (sync latency case under IRR_SYNC_EN).
module tb_irr_bank;
    localparam int N = 8;
`ifdef IRR_SYNC_EN
    localparam int SS = 3;
`else
    localparam int SS = 2;
`endif

    typedef struct {
        string       tag;
        logic [N-1:0] exp;
        logic [15:0]  exp16;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frz = 1'b0;
    logic [N-1:0] irr = '0, ltim = '0, inta = '0;
    logic [N-1:0] pri, ctl;
    logic any;
    logic [15:0] irr16 = '0;
    int errors = 0, checks = 0;
    sb_t sb[$];
    logic [N-1:0] m_pend = '0, m_prev = '0, m_hold = '0, m_blk = '0;

    always #5 clk = ~clk;

    irr_bank #(.N_IRQ(N), .SYNC_STAGES(SS)) u_dut (
        .clk          (clk),
        .IRR_reset    (rst),
        .IRR          (irr),
        .LTIM         (ltim),
        .INTA_FREEZE  (frz),
        .INTA_1       (inta),
        .IRR_priority (pri),
        .IRR_control  (ctl),
        .irr_any      (any)
    );

`ifdef IRR_SYNC_EN
    logic [15:0] pri16, ctl16;
    logic any16;
    irr_bank #(.N_IRQ(16), .SYNC_STAGES(3)) u_dut16 (
        .clk          (clk),
        .IRR_reset    (rst),
        .IRR          (irr16),
        .LTIM         (16'h0000),
        .INTA_FREEZE  (1'b0),
        .INTA_1       (16'h0000),
        .IRR_priority (pri16),
        .IRR_control  (ctl16),
        .irr_any      (any16)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic [N-1:0] i, input logic [N-1:0] l,
                         input logic f, input logic [N-1:0] a);
        if (r) begin
            m_pend = '0; m_prev = '0; m_hold = '0; m_blk = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                logic rs;
                rs = i[k] && !m_prev[k];
                if (f) begin
                    m_pend[k] = m_pend[k] && !a[k];
                    if (!l[k] && rs) m_hold[k] = 1'b1;
                end else begin
                    if (l[k]) m_pend[k] = (i[k] && !m_blk[k] && !a[k]) || m_hold[k];
                    else      m_pend[k] = (m_pend[k] && !a[k]) || rs || m_hold[k];
                    m_hold[k] = 1'b0;
                end
                m_blk[k]  = l[k] && (a[k] || (m_blk[k] && i[k]));
                m_prev[k] = i[k];
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [N-1:0] i, input logic [N-1:0] l,
                        input logic f, input logic [N-1:0] a, input logic [N-1:0] exp,
                        input logic use_m = 1'b0, input logic [15:0] i16 = '0, input logic [15:0] e16 = '0);
        @(negedge clk);
        rst = r; irr = i; ltim = l; frz = f; inta = a; irr16 = i16;
        model(r, i, l, f, a);
        sb.push_back('{tag, use_m ? m_pend : exp, e16});
    endtask

    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, ".pri"}, 32'(pri), 32'(e.exp));
                chk({e.tag, ".ctl"}, 32'(ctl), 32'(e.exp));
                chk({e.tag, ".any"}, 32'(any), 32'(|e.exp));
`ifdef IRR_SYNC_EN
                chk({e.tag, ".pri16"}, 32'(pri16), 32'(e.exp16));
                chk({e.tag, ".ctl16"}, 32'(ctl16), 32'(e.exp16));
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] rl;
`ifdef IRR_SYNC_EN
        step("rst0", 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        step("rst1", 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        step("sync_c1", 0, 8'h80, 8'h00, 0, 8'h00, 8'h00, 0, 16'h8000, 16'h0000);
        step("sync_c2", 0, 8'h80, 8'h00, 0, 8'h00, 8'h00, 0, 16'h8000, 16'h0000);
        step("sync_c3", 0, 8'h80, 8'h00, 0, 8'h00, 8'h00, 0, 16'h8000, 16'h0000);
        step("sync_c4", 0, 8'h80, 8'h00, 0, 8'h00, 8'h80, 0, 16'h8000, 16'h8000);
        step("sync_hold", 0, 8'h80, 8'h00, 0, 8'h00, 8'h80, 0, 16'h8000, 16'h8000);
`else
        step("rst0", 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
        step("rst1", 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
        step("rst_rel", 0, 8'hFF, 8'h00, 0, 8'h00, 8'hFF);
        step("clr", 0, 8'h00, 8'h00, 0, 8'hFF, 8'h00);
        step("edge_set", 0, 8'hF0, 8'h00, 0, 8'h00, 8'hF0);
        step("edge_sticky", 0, 8'hC0, 8'h00, 0, 8'h00, 8'hF0);
        step("edge_ack", 0, 8'hC0, 8'h00, 0, 8'h10, 8'hE0);
        step("clr2", 0, 8'h00, 8'h00, 0, 8'hFF, 8'h00);
        step("collide", 0, 8'h20, 8'h00, 0, 8'h20, 8'h20);
        step("frz_rise", 0, 8'h23, 8'h00, 1, 8'h00, 8'h20);
        step("frz_ack", 0, 8'h23, 8'h00, 1, 8'h20, 8'h00);
        step("frz_merge", 0, 8'h23, 8'h00, 0, 8'h00, 8'h03);
        step("frz_ack0", 0, 8'h23, 8'h00, 1, 8'h01, 8'h02);
        step("frz_rel", 0, 8'h23, 8'h00, 0, 8'h00, 8'h02);
        step("clr3", 0, 8'h00, 8'h00, 0, 8'hFF, 8'h00);
        step("lvl_set", 0, 8'h0C, 8'hFF, 0, 8'h00, 8'h0C);
        step("lvl_ack", 0, 8'h0C, 8'hFF, 0, 8'h04, 8'h08);
        step("lvl_blk", 0, 8'h0C, 8'hFF, 0, 8'h00, 8'h08);
        step("lvl_low", 0, 8'h08, 8'hFF, 0, 8'h00, 8'h08);
        step("lvl_retrig", 0, 8'h0C, 8'hFF, 0, 8'h00, 8'h0C);
        step("lvl_drop", 0, 8'h00, 8'hFF, 0, 8'h00, 8'h00);
        step("rfrz_a", 0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        step("rfrz_b", 0, 8'h81, 8'h00, 1, 8'h00, 8'h00);
        step("rfrz_rst", 1, 8'h81, 8'h00, 1, 8'h00, 8'h00);
        step("rfrz_rel", 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        rl = '0;
        for (int k = 0; k < 300; k++) begin
            if (k % 16 == 0) rl = N'($urandom);
            step("rnd", 0, N'($urandom), rl, $urandom_range(0, 3) == 0,
                 N'($urandom) & N'($urandom) & N'($urandom), '0, 1);
        end
`endif
        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
